// File: rtl/fxp_act_pkg.sv
// -----------------------------------------------------------------------------
// fxp_act_pkg
// Shared definitions for the fixed-point activation pipeline:
//   - mode_e           : per-transaction activation selector (sigmoid / tanh)
//   - fx_* functions   : PWL breakpoints and offsets in LSB units, built from
//                        the number of fraction bits so the same code scales
//                        with the Q format.
// No ports; imported by fxp_sigmoid_pwl_core and fixed_point_activation_pipe.
// -----------------------------------------------------------------------------
package fxp_act_pkg;

  typedef enum logic {
    MODE_SIGMOID = 1'b0,
    MODE_TANH    = 1'b1
  } mode_e;

  localparam int DEFAULT_INTEGER  = 4;
  localparam int DEFAULT_FRACTION = 6;

  // 1.0
  function automatic int fx_one(input int frac);
    return 1 << frac;
  endfunction

  // 2.375 = 19/8; exact for frac >= 3
  function automatic int fx_bp_2p375(input int frac);
    return 19 << (frac - 3);
  endfunction

  // 5.0
  function automatic int fx_bp_5p0(input int frac);
    return 5 << frac;
  endfunction

  // 0.5
  function automatic int fx_off_0p5(input int frac);
    return 1 << (frac - 1);
  endfunction

  // 0.625 = 5/8
  function automatic int fx_off_0p625(input int frac);
    return 5 << (frac - 3);
  endfunction

  // 0.84375 = 27/32; this is the constant that needs frac >= 5
  function automatic int fx_off_0p84375(input int frac);
    return 27 << (frac - 5);
  endfunction

endpackage

// File: rtl/fxp_sigmoid_pwl_core.sv
// -----------------------------------------------------------------------------
// fxp_sigmoid_pwl_core
// Combinational piecewise-linear approximation of sigmoid for a non-negative
// argument. Selects the segment from the magnitude and adds the segment offset
// to a truncating right shift of the magnitude. The result lies in [0.5, 1.0].
//
// Ports:
//   a  in   DATA_WIDTH-1  unsigned magnitude, FRACTION fraction bits
//   s  out  DATA_WIDTH    unsigned sigmoid(a), FRACTION fraction bits
// -----------------------------------------------------------------------------
module fxp_sigmoid_pwl_core
  import fxp_act_pkg::*;
#(
  parameter int FRACTION   = DEFAULT_FRACTION,
  parameter int DATA_WIDTH = DEFAULT_INTEGER + DEFAULT_FRACTION
) (
  input  logic [DATA_WIDTH-2:0] a,
  output logic [DATA_WIDTH-1:0] s
);

  localparam int MAG_WIDTH = DATA_WIDTH - 1;

  localparam logic [MAG_WIDTH-1:0]  BP_1P0     = MAG_WIDTH'(fx_one(FRACTION));
  localparam logic [MAG_WIDTH-1:0]  BP_2P375   = MAG_WIDTH'(fx_bp_2p375(FRACTION));
  localparam logic [MAG_WIDTH-1:0]  BP_5P0     = MAG_WIDTH'(fx_bp_5p0(FRACTION));
  localparam logic [DATA_WIDTH-1:0] S_ONE      = DATA_WIDTH'(fx_one(FRACTION));
  localparam logic [DATA_WIDTH-1:0] OFF_0P5    = DATA_WIDTH'(fx_off_0p5(FRACTION));
  localparam logic [DATA_WIDTH-1:0] OFF_0P625  = DATA_WIDTH'(fx_off_0p625(FRACTION));
  localparam logic [DATA_WIDTH-1:0] OFF_0P8438 = DATA_WIDTH'(fx_off_0p84375(FRACTION));

  // The slopes 1/32, 1/8 and 1/4 are scale-free, so the shift amounts do not
  // depend on FRACTION. Shifting the unsigned magnitude floors the product.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the if/else chain can leave it unassigned and infer a latch.
    s = OFF_0P5;
    if (a >= BP_5P0) begin
      s = S_ONE;
    end else if (a >= BP_2P375) begin
      s = DATA_WIDTH'(a >> 5) + OFF_0P8438;
    end else if (a >= BP_1P0) begin
      s = DATA_WIDTH'(a >> 3) + OFF_0P625;
    end else begin
      s = DATA_WIDTH'(a >> 2) + OFF_0P5;
    end
  end

endmodule

// File: rtl/fixed_point_activation_pipe.sv
// -----------------------------------------------------------------------------
// fixed_point_activation_pipe
// Three-stage valid/ready pipeline computing PWL sigmoid or PWL tanh on a
// signed Q(INTEGER.FRACTION) sample. Negative inputs are folded to a magnitude
// and restored through the odd/point symmetry of the functions:
//   sigmoid(-x) = 1 - sigmoid(x),  tanh(x) = 2*sigmoid(2x) - 1,  tanh(-x) = -tanh(x)
//
//   stage 1 : sign and saturated magnitude (doubled for tanh)
//   stage 2 : positive-sigmoid PWL (fxp_sigmoid_pwl_core)
//   stage 3 : symmetry / tanh post-processing, drives the outputs
//
// All stages advance together on adv = !out_valid || out_ready, so a stall
// freezes the whole pipe and in_ready follows out_ready combinationally.
//
// Ports:
//   clk        in   1           rising-edge clock
//   rst        in   1           synchronous active-high reset
//   in_valid   in   1           input sample valid
//   in_ready   out  1           sample accepted on this edge when valid
//   in_data    in   DATA_WIDTH  signed input x
//   in_mode    in   1           0 = sigmoid, 1 = tanh
//   in_tag     in   TAG_WIDTH   sideband, returned unchanged with the result
//   out_valid  out  1           result valid
//   out_ready  in   1           downstream accepts the result
//   out_data   out  DATA_WIDTH  signed result
//   out_tag    out  TAG_WIDTH   tag of the result
// -----------------------------------------------------------------------------
module fixed_point_activation_pipe
  import fxp_act_pkg::*;
#(
  parameter int INTEGER    = DEFAULT_INTEGER,
  parameter int FRACTION   = DEFAULT_FRACTION,
  parameter int DATA_WIDTH = INTEGER + FRACTION,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_mode,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [TAG_WIDTH-1:0]  out_tag
);

  localparam int MAG_WIDTH = DATA_WIDTH - 1;

  // Largest positive sample value, as an unsigned magnitude and zero-extended
  // to the width of the doubled magnitude for the saturation compare.
  localparam logic [MAG_WIDTH-1:0]  MAG_MAX     = '1;
  localparam logic [DATA_WIDTH+1:0] MAG_MAX_EXT = {3'b000, MAG_MAX};
  localparam logic [DATA_WIDTH-1:0] ONE         = DATA_WIDTH'(fx_one(FRACTION));

  // ---------------------------------------------------------------------------
  // Stage registers
  // ---------------------------------------------------------------------------
  logic                  s1_valid;
  logic                  s1_sign;
  mode_e                 s1_mode;
  logic [MAG_WIDTH-1:0]  s1_a;
  logic [TAG_WIDTH-1:0]  s1_tag;

  logic                  s2_valid;
  logic                  s2_sign;
  mode_e                 s2_mode;
  logic [DATA_WIDTH-1:0] s2_s;
  logic [TAG_WIDTH-1:0]  s2_tag;

  logic                  s3_valid;
  logic [DATA_WIDTH-1:0] s3_data;
  logic [TAG_WIDTH-1:0]  s3_tag;

  // ---------------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------------
  logic adv;
  logic accept;

  assign adv      = !s3_valid || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;

  // ---------------------------------------------------------------------------
  // Stage 1 logic: magnitude with saturation
  // ---------------------------------------------------------------------------
  mode_e                 in_mode_e;
  logic [DATA_WIDTH:0]   x_ext;
  logic [DATA_WIDTH:0]   abs_x;
  logic [DATA_WIDTH+1:0] scaled;
  logic [MAG_WIDTH-1:0]  a_next;

  assign in_mode_e = mode_e'(in_mode);

  always_comb begin
    // One extra bit so |most-negative| is representable before saturating.
    x_ext  = {in_data[DATA_WIDTH-1], in_data};
    abs_x  = in_data[DATA_WIDTH-1] ? (~x_ext + 1'b1) : x_ext;
    // tanh(x) is evaluated as 2*sigmoid(2x) - 1, hence the doubled argument.
    scaled = (in_mode_e == MODE_TANH) ? {abs_x, 1'b0} : {1'b0, abs_x};
    a_next = (scaled > MAG_MAX_EXT) ? MAG_MAX : scaled[MAG_WIDTH-1:0];
  end

  // ---------------------------------------------------------------------------
  // Stage 2 logic: PWL core
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] s_pwl;

  fxp_sigmoid_pwl_core #(
    .FRACTION   (FRACTION),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_pwl_core (
    .a (s1_a),
    .s (s_pwl)
  );

  // ---------------------------------------------------------------------------
  // Stage 3 logic: symmetry and tanh mapping. With s in [0.5, 1.0] every
  // intermediate stays within +/-1.0, so DATA_WIDTH arithmetic is exact.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] t_val;
  logic [DATA_WIDTH-1:0] y_next;

  always_comb begin
    t_val = {s2_s[DATA_WIDTH-2:0], 1'b0} - ONE;
    if (s2_mode == MODE_TANH) begin
      y_next = s2_sign ? (-t_val) : t_val;
    end else begin
      y_next = s2_sign ? (ONE - s2_s) : s2_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline registers. Data fields load only when the stage feeding them
  // holds a valid sample, so out_data/out_tag keep the last result between
  // transfers and never change while a result is waiting.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: datapath registers are reset along with the valids because the
    // outputs must read zero after reset; state updates use non-blocking
    // assignments so every stage samples its upstream value from before the
    // edge.
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_mode  <= MODE_SIGMOID;
      s1_a     <= '0;
      s1_tag   <= '0;
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_mode  <= MODE_SIGMOID;
      s2_s     <= '0;
      s2_tag   <= '0;
      s3_valid <= 1'b0;
      s3_data  <= '0;
      s3_tag   <= '0;
    end else if (adv) begin
      s1_valid <= accept;
      if (accept) begin
        s1_sign <= in_data[DATA_WIDTH-1];
        s1_mode <= in_mode_e;
        s1_a    <= a_next;
        s1_tag  <= in_tag;
      end

      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sign <= s1_sign;
        s2_mode <= s1_mode;
        s2_s    <= s_pwl;
        s2_tag  <= s1_tag;
      end

      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_data <= y_next;
        s3_tag  <= s2_tag;
      end
    end
  end

  assign out_valid = s3_valid;
  assign out_data  = s3_data;
  assign out_tag   = s3_tag;

endmodule

// File: tb/tb_fixed_point_activation_pipe.sv
// -----------------------------------------------------------------------------
// tb_fixed_point_activation_pipe
// Self-checking bench for fixed_point_activation_pipe at default parameters
// (Q4.6). Directed vectors from a table, hand-written reset and latency
// sequences, and a randomized stream scored against an arithmetic model of the
// activation equations.
// -----------------------------------------------------------------------------
module tb_fixed_point_activation_pipe;

  localparam int DW = 10;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_mode;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [TW-1:0] out_tag;

  int total = 0;
  int bad   = 0;

  fixed_point_activation_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] x;
    logic          mode;
    logic [DW-1:0] exp;
  } vec_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
  } item_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Activation computed directly from the PWL rules in LSB units (1/64).
  function automatic logic [DW-1:0] model(input logic [DW-1:0] x, input logic mode);
    int xi;
    int ax;
    int s;
    int y;
    xi = int'($signed(x));
    ax = (xi < 0) ? -xi : xi;
    if (mode) ax = 2 * ax;
    if (ax > 511) ax = 511;
    if (ax >= 320)      s = 64;
    else if (ax >= 152) s = ax / 32 + 54;
    else if (ax >= 64)  s = ax / 8 + 40;
    else                s = ax / 4 + 32;
    if (mode) begin
      y = 2 * s - 64;
      if (xi < 0) y = -y;
    end else begin
      y = (xi < 0) ? 64 - s : s;
    end
    return DW'(y);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One isolated transaction with out_ready high: checks acceptance, that
  // out_valid stays low for two cycles after the transfer edge and rises on
  // the third stage register, and the result value and tag.
  task automatic run_one(input logic [DW-1:0] x, input logic mode, input logic [TW-1:0] tag,
                         input logic [DW-1:0] exp, input string name);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = x;
    in_mode   = mode;
    in_tag    = tag;
    #1;
    check({name, " in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check({name, " early_valid1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({name, " early_valid2"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({name, " out_valid"}, 32'(out_valid), 32'd1);
    check({name, " data"}, 32'(out_data), 32'(exp));
    check({name, " tag"}, 32'(out_tag), 32'(tag));
  endtask

  // Streaming run with random stalls. fixed_seq uses tags 0..n-1 with modes
  // alternating; otherwise data, mode, tag and valid gaps are random.
  task automatic run_stream(input int n, input bit fixed_seq, input int ready_pct, input string name);
    item_t         exp_q[$];
    item_t         it;
    item_t         head;
    int            sent = 0;
    int            got = 0;
    int            cycles = 0;
    bit            have = 1'b0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [TW-1:0] prev_tag = '0;
    logic [DW-1:0] x;
    logic          m;
    logic [TW-1:0] tg;
    x = '0; m = 1'b0; tg = '0;
    while ((sent < n || got < sent) && cycles < 20 * n + 100) begin
      @(negedge clk);
      cycles++;
      if (prev_stall) begin
        check({name, " stall_data"}, 32'(out_data), 32'(prev_data));
        check({name, " stall_tag"}, 32'(out_tag), 32'(prev_tag));
      end
      if (!have && sent < n && (fixed_seq || $urandom_range(99) < 80)) begin
        if (fixed_seq) begin
          x  = DW'($urandom);
          m  = sent[0];
          tg = TW'(sent);
        end else begin
          case ($urandom_range(7))
            0:       x = 10'h200;
            1:       x = 10'h1FF;
            default: x = DW'($urandom);
          endcase
          m  = 1'($urandom);
          tg = TW'($urandom);
        end
        have = 1'b1;
      end
      in_valid  = have;
      in_data   = x;
      in_mode   = m;
      in_tag    = tg;
      out_ready = ($urandom_range(99) < ready_pct);
      #1;
      check({name, " in_ready"}, 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check({name, " spurious_out"}, 32'(out_valid), 32'd0);
        end else begin
          head = exp_q.pop_front();
          check({name, " data"}, 32'(out_data), 32'(head.data));
          check({name, " tag"}, 32'(out_tag), 32'(head.tag));
          got++;
        end
      end
      if (have && in_ready) begin
        it.data = model(x, m);
        it.tag  = tg;
        exp_q.push_back(it);
        sent++;
        have = 1'b0;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_tag   = out_tag;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check({name, " completed"}, 32'(got), 32'(n));
  endtask

  initial begin
    bit seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = 1'b0;
    in_tag    = '0;
    out_ready = 1'b1;

    vecs[0]  = '{x: 10'd32,  mode: 1'b0, exp: 10'd40};
    vecs[1]  = '{x: 10'h3E0, mode: 1'b0, exp: 10'd24};
    vecs[2]  = '{x: 10'd96,  mode: 1'b0, exp: 10'd52};
    vecs[3]  = '{x: 10'd192, mode: 1'b0, exp: 10'd60};
    vecs[4]  = '{x: 10'd384, mode: 1'b0, exp: 10'd64};
    vecs[5]  = '{x: 10'd32,  mode: 1'b1, exp: 10'd32};
    vecs[6]  = '{x: 10'h3E0, mode: 1'b1, exp: 10'h3E0};
    vecs[7]  = '{x: 10'd0,   mode: 1'b1, exp: 10'd0};
    vecs[8]  = '{x: 10'd320, mode: 1'b1, exp: 10'd64};
    vecs[9]  = '{x: 10'h200, mode: 1'b0, exp: 10'd0};
    vecs[10] = '{x: 10'h200, mode: 1'b1, exp: 10'h3C0};

    do_reset();
    #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data", 32'(out_data), 32'd0);
    check("reset out_tag", 32'(out_tag), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 11; i++) begin
      run_one(vecs[i].x, vecs[i].mode, TW'(i + 3), vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Backpressure: tags 0..7 with alternating modes.
    run_stream(8, 1'b1, 50, "bp8");

    // Reset with the pipe full and stalled.
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 10'd96;
      in_mode  = 1'b0;
      in_tag   = TW'(i + 1);
      #1;
      check($sformatf("rst_fill%0d in_ready", i), 32'(in_ready), 32'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("rst_fill out_valid", 32'(out_valid), 32'd1);
    check("rst_fill in_ready", 32'(in_ready), 32'd0);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 10'd32;
    in_tag   = 4'd9;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    check("rst_mid out_valid", 32'(out_valid), 32'd0);
    check("rst_mid in_ready", 32'(in_ready), 32'd1);
    check("rst_mid out_data", 32'(out_data), 32'd0);
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("rst_mid flushed", 32'(seen), 32'd0);
    run_one(10'd32, 1'b0, 4'd5, 10'd40, "post_rst");

    // Random traffic against the model.
    run_stream(10000, 1'b0, 70, "rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
